// File: rtl/floor_pkg.sv
// Shared constants and the read-tag record for the floor tile ROM arbiter.
package floor_pkg;

    localparam int PORT_VIDEO       = 0;
    localparam int PORT_LOGIC       = 1;
    localparam int FLOOR_RD_LATENCY = 2;
    localparam int FLOOR_TILE_W     = 20;
    localparam int FLOOR_TILE_H     = 20;

    typedef struct packed {
        logic valid;
        logic port;
        logic oob;
    } floor_tag_t;

endpackage

// File: rtl/floor_rom_arbiter.sv
// Two-port priority arbiter in front of a synchronous floor tile ROM, with
// starvation protection for the logic port and a fixed 2-clock read return.
module floor_rom_arbiter
    import floor_pkg::*;
#(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDR_WIDTH   = 20,
    parameter int ROM_SIZE     = 400,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  p0_req,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    output logic                  p0_gnt,
    output logic                  p0_valid,
    output logic [DATA_WIDTH-1:0] p0_data,
    input  logic                  p1_req,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    output logic                  p1_gnt,
    output logic                  p1_valid,
    output logic [DATA_WIDTH-1:0] p1_data,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  oob_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]      r_starve_cnt;
    logic [CNT_W-1:0]      w_starve_nxt;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_oob_err;
    floor_tag_t            r_tag [FLOOR_RD_LATENCY];
    floor_tag_t            w_ret_tag;
    logic                  w_force1;
    logic                  w_p0_gnt;
    logic                  w_p1_gnt;
    logic                  w_gnt_any;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_oob;

    // Grant selection, issued address and starvation counter next value
    always_comb begin
        w_force1  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
        w_p0_gnt  = 1'b0;
        w_p1_gnt  = 1'b0;
        if (w_force1 && p1_req) begin
            w_p1_gnt = 1'b1;
        end else if (p0_req) begin
            w_p0_gnt = 1'b1;
        end else if (p1_req) begin
            w_p1_gnt = 1'b1;
        end else begin
            w_p1_gnt = 1'b0;
        end
        w_gnt_any = w_p0_gnt | w_p1_gnt;
        w_addr    = w_p1_gnt ? p1_addr : p0_addr;
        w_oob     = w_gnt_any && (w_addr >= ADDR_WIDTH'(ROM_SIZE));
        if (!p1_req || w_p1_gnt) begin
            w_starve_nxt = {CNT_W{1'b0}};
        end else if (!w_force1) begin
            w_starve_nxt = r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // Issue register, error pulse, starvation counter and tag pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rom_addr   <= {ADDR_WIDTH{1'b0}};
            r_oob_err    <= 1'b0;
            r_starve_cnt <= {CNT_W{1'b0}};
            for (int i = 0; i < FLOOR_RD_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                // Out-of-range reads are steered to word 0 and their data masked on return
                r_rom_addr <= w_oob ? {ADDR_WIDTH{1'b0}} : w_addr;
            end else begin
                r_rom_addr <= r_rom_addr;
            end
            r_oob_err    <= w_oob;
            r_starve_cnt <= w_starve_nxt;
            r_tag[0]     <= '{valid: w_gnt_any, port: w_p1_gnt, oob: w_oob};
            for (int i = 1; i < FLOOR_RD_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_ret_tag = r_tag[FLOOR_RD_LATENCY-1];

    assign p0_gnt   = w_p0_gnt;
    assign p1_gnt   = w_p1_gnt;
    assign rom_addr = r_rom_addr;
    assign oob_err  = r_oob_err;
    assign p0_valid = w_ret_tag.valid && (w_ret_tag.port == 1'(PORT_VIDEO));
    assign p1_valid = w_ret_tag.valid && (w_ret_tag.port == 1'(PORT_LOGIC));
    assign p0_data  = (p0_valid && !w_ret_tag.oob) ? rom_data : {DATA_WIDTH{1'b0}};
    assign p1_data  = (p1_valid && !w_ret_tag.oob) ? rom_data : {DATA_WIDTH{1'b0}};

endmodule
